// File: rtl/adf_multi_loader.sv
// Sequential loader for NCH ADF4350 synthesizers on one shared 3-wire bus.
// Optional lock supervision is compiled in with `define ADF_LOCK_WAIT_EN.
module adf_multi_loader #(
  parameter int NCH      = 2,
  parameter int CLK_DIV  = 4,
  parameter int LOCK_TMO = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_ch,
  input  logic [2:0]      cfg_idx,
  input  logic [31:0]     cfg_data,
  input  logic            start,
  input  logic [2:0]      start_ch,
  output logic            busy,
  output logic            done,
  output logic            d_clk,
  output logic            d_out,
  output logic [NCH-1:0]  d_le,
  input  logic [NCH-1:0]  ld,
  output logic [NCH-1:0]  locked,
  output logic            lock_err,
  output logic [2:0]      dbg_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] LATCH    = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;
  localparam logic [2:0] LOCKWAIT = 3'd6;
  localparam logic [2:0] FIN      = 3'd7;

  logic [31:0] shadow [NCH][6];
  logic [31:0] ld_word;
  logic [31:0] sreg;
  logic [2:0]  state;
  logic [2:0]  cur_ch;
  logic [2:0]  reg_idx;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        div_end;

  assign div_end = (div_cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < 6; i++)
          shadow[c][i] <= '0;
    end else if (cfg_we) begin
      // Out-of-range channel or index matches no entry and is dropped.
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < 6; i++)
          if (cfg_ch == 3'(c) && cfg_idx == 3'(i))
            shadow[c][i] <= cfg_data;
    end
  end

  always_comb begin
    ld_word = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 6; i++)
        if (cur_ch == 3'(c) && reg_idx == 3'(i))
          ld_word = shadow[c][i];
  end

`ifdef ADF_LOCK_WAIT_EN
  logic [NCH-1:0] ld_s1, ld_s2;
  logic           ld_sel;
  logic [4:0]     lock_cnt;
  logic [31:0]    tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_s1 <= '0;
      ld_s2 <= '0;
    end else begin
      ld_s1 <= ld;
      ld_s2 <= ld_s1;
    end
  end

  always_comb begin
    ld_sel = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (cur_ch == 3'(c)) ld_sel = ld_s2[c];
  end
`else
  logic unused_lock;
  assign unused_lock = ^{ld, 32'(LOCK_TMO)};
  assign locked      = '0;
  assign lock_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_ch  <= '0;
      reg_idx <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sreg    <= '0;
`ifdef ADF_LOCK_WAIT_EN
      locked   <= '0;
      lock_err <= 1'b0;
      lock_cnt <= '0;
      tmo_cnt  <= '0;
`endif
    end else begin
`ifdef ADF_LOCK_WAIT_EN
      lock_err <= 1'b0;
`endif
      case (state)
        IDLE: if (start && ({1'b0, start_ch} < 4'(NCH))) begin
          cur_ch  <= start_ch;
          reg_idx <= 3'd5;
          state   <= LOAD;
        end
        // LOAD counts as the first cycle of bit 31's low phase.
        LOAD: begin
          sreg    <= ld_word;
          div_cnt <= 8'd1;
          bit_cnt <= '0;
          state   <= SHIFT_LO;
        end
        SHIFT_LO: if (div_end) begin
          div_cnt <= '0;
          state   <= SHIFT_HI;
        end else div_cnt <= div_cnt + 8'd1;
        SHIFT_HI: if (div_end) begin
          div_cnt <= '0;
          if (bit_cnt == 5'd31) state <= LATCH;
          else begin
            sreg    <= {sreg[30:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            state   <= SHIFT_LO;
          end
        end else div_cnt <= div_cnt + 8'd1;
        LATCH: if (div_end) begin
          div_cnt <= '0;
          state   <= GAP;
        end else div_cnt <= div_cnt + 8'd1;
        GAP: if (div_end) begin
          div_cnt <= '0;
          if (reg_idx == 3'd0) begin
`ifdef ADF_LOCK_WAIT_EN
            state    <= LOCKWAIT;
            lock_cnt <= '0;
            tmo_cnt  <= '0;
            for (int c = 0; c < NCH; c++)
              if (cur_ch == 3'(c)) locked[c] <= 1'b0;
`else
            state <= FIN;
`endif
          end else begin
            reg_idx <= reg_idx - 3'd1;
            state   <= LOAD;
          end
        end else div_cnt <= div_cnt + 8'd1;
        LOCKWAIT: begin
`ifdef ADF_LOCK_WAIT_EN
          tmo_cnt <= tmo_cnt + 32'd1;
          if (ld_sel && lock_cnt == 5'd15) begin
            for (int c = 0; c < NCH; c++)
              if (cur_ch == 3'(c)) locked[c] <= 1'b1;
            state <= FIN;
          end else if (tmo_cnt == 32'(LOCK_TMO - 1)) begin
            lock_err <= 1'b1;
            state    <= FIN;
          end else begin
            lock_cnt <= ld_sel ? lock_cnt + 5'd1 : 5'd0;
          end
`else
          state <= FIN;
`endif
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    d_le = '0;
    if (state == LATCH)
      for (int c = 0; c < NCH; c++)
        d_le[c] = (cur_ch == 3'(c));
  end

  // Bus pins decode from state so reset clears them without waiting for a clock.
  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign d_clk     = (state == SHIFT_HI);
  assign d_out     = ((state == SHIFT_LO) || (state == SHIFT_HI)) && sreg[31];
  assign dbg_state = state;

endmodule

// File: tb/tb_adf_multi_loader.sv
// Bench for adf_multi_loader: decodes the serial bus and scores each latched
// word against a queue filled from a shadow-register model.
module tb_adf_multi_loader;
  localparam int NCH      = 2;
  localparam int CLK_DIV  = 4;
  localparam int LOCK_TMO = 1000;
`ifdef ADF_LOCK_WAIT_EN
  localparam bit LW = 1'b1;
`else
  localparam bit LW = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_ch = '0;
  logic [2:0]     cfg_idx = '0;
  logic [31:0]    cfg_data = '0;
  logic           start = 1'b0;
  logic [2:0]     start_ch = '0;
  logic           busy, done, d_clk, d_out, lock_err;
  logic [NCH-1:0] d_le, locked;
  logic [NCH-1:0] ld = '0;
  logic [2:0]     dbg_state;

  adf_multi_loader #(.NCH(NCH), .CLK_DIV(CLK_DIV), .LOCK_TMO(LOCK_TMO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .start(start), .start_ch(start_ch), .busy(busy),
    .done(done), .d_clk(d_clk), .d_out(d_out), .d_le(d_le), .ld(ld),
    .locked(locked), .lock_err(lock_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc_pos = 0;
  int done_cnt = 0;
  int le_pulses = 0;
  logic [31:0]    exp_q[$];
  logic [31:0]    shadow_m [NCH][6];
  logic [NCH-1:0] locked_m = '0;
  logic [NCH-1:0] exp_le = '0;

  always @(posedge clk) cyc_pos++;

  // Bus monitor: bits captured on D_CLK rise, word scored on D_LE rise.
  logic [31:0]    shift_w = '0;
  int             nbits = 0, hi_len = 0, le_len = 0;
  logic           prev_dclk = 1'b0;
  logic [NCH-1:0] prev_le = '0;
  always @(negedge clk) begin
    if (rst) begin
      shift_w = '0; nbits = 0; hi_len = 0; le_len = 0;
      prev_dclk = 1'b0; prev_le = '0;
    end else begin
      if (done) done_cnt++;
      if (d_clk && !prev_dclk) begin
        shift_w = {shift_w[30:0], d_out};
        nbits++;
      end
      if (d_clk) hi_len++;
      if (!d_clk && prev_dclk) begin
        n_total++;
        if (hi_len !== CLK_DIV) $display("FAIL dclk_high_len: got %0d expected %0d", hi_len, CLK_DIV);
        else n_pass++;
        hi_len = 0;
      end
      if (d_le != '0) le_len++;
      if (d_le != '0 && prev_le == '0) begin
        le_pulses++;
        n_total++;
        if (d_le !== exp_le) $display("FAIL le_select: got %b expected %b", d_le, exp_le);
        else n_pass++;
        n_total++;
        if (nbits !== 32) $display("FAIL word_bits: got %0d expected 32", nbits);
        else n_pass++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL word_unexpected: got %h expected none", shift_w);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (shift_w !== e) $display("FAIL word_data: got %h expected %h", shift_w, e);
          else n_pass++;
        end
        nbits = 0;
      end
      if (d_le == '0 && prev_le != '0) begin
        n_total++;
        if (le_len !== CLK_DIV) $display("FAIL le_len: got %0d expected %0d", le_len, CLK_DIV);
        else n_pass++;
        le_len = 0;
      end
      prev_dclk = d_clk;
      prev_le   = d_le;
    end
  end

  task automatic write_cfg(input int ch, input int idx, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_idx = 3'(idx); cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ch < NCH && idx < 6) shadow_m[ch][idx] = data;
  endtask

  task automatic load_ch0();
    logic [31:0] words [6];
    words = '{32'h00320000, 32'h08008011, 32'h00004E42,
              32'h000004B3, 32'h00A5003C, 32'h00580005};
    for (int i = 0; i < 6; i++) write_cfg(0, i, words[i]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, d_clk, d_out, d_le, locked, lock_err} !== '0)
      $display("FAIL reset_outputs: got %b expected 0", {busy, done, d_clk, d_out, d_le, locked, lock_err});
    else n_pass++;
    n_total++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 6; i++) shadow_m[c][i] = '0;
  endtask

  // mid=1 adds a config write during the R5 shift plus ignored writes and a START while busy.
  task automatic run_seq(input int ch, input bit mid);
    int t0, lat, exp_lat, d0;
    bit got;
    logic exp_err;
    exp_le = NCH'(1 << ch);
    le_pulses = 0;
    d0 = done_cnt;
    exp_lat = 1 + 6*66*CLK_DIV + (LW ? (ld[ch] ? 16 : LOCK_TMO) : 0);
    exp_err = LW && !ld[ch];
    @(negedge clk);
    start = 1'b1; start_ch = 3'(ch); t0 = cyc_pos;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy);
    else n_pass++;
    if (mid) begin
      repeat (20) @(negedge clk);
      write_cfg(ch, 0, 32'h00000001);
      write_cfg(ch, 6, 32'hDEADBEEF);
      write_cfg(2, 0, 32'hFFFFFFFF);
      start = 1'b1; start_ch = 3'(ch ^ 1);
      @(negedge clk);
      start_ch = 3'd5;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 5; i >= 0; i--) exp_q.push_back(shadow_m[ch][i]);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 6000 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc_pos - t0;
      end
    end
    n_total++;
    if (!got) $display("FAIL done_timeout: got 0 expected 1");
    else n_pass++;
    n_total++;
    if (lat !== exp_lat) $display("FAIL done_latency: got %0d expected %0d", lat, exp_lat);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL busy_at_done: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (lock_err !== exp_err) $display("FAIL lock_err: got %b expected %b", lock_err, exp_err);
    else n_pass++;
    if (LW) locked_m[ch] = ld[ch];
    n_total++;
    if (locked !== locked_m) $display("FAIL locked: got %b expected %b", locked, locked_m);
    else n_pass++;
    repeat (30) @(negedge clk);
    n_total++;
    if (le_pulses !== 6) $display("FAIL le_pulses: got %0d expected 6", le_pulses);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL words_left: got %0d expected 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL done_count: got %0d expected 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if ({dbg_state, d_clk, d_out, d_le} !== '0)
      $display("FAIL idle_bus: got %b expected 0", {dbg_state, d_clk, d_out, d_le});
    else n_pass++;
  endtask

  task automatic test_bad_start();
    @(negedge clk);
    start = 1'b1; start_ch = 3'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      n_total++;
      if ({busy, dbg_state} !== '0) $display("FAIL bad_start: got %b expected 0", {busy, dbg_state});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    load_ch0();
    exp_le = 2'b01;
    @(negedge clk);
    start = 1'b1; start_ch = 3'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 5; i >= 0; i--) exp_q.push_back(shadow_m[0][i]);
    repeat (100 * 2 * CLK_DIV) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({busy, done, d_clk, d_out, d_le, locked, lock_err} !== '0)
      $display("FAIL reset_mid_outputs: got %b expected 0", {busy, done, d_clk, d_out, d_le, locked, lock_err});
    else n_pass++;
    exp_q.delete();
    locked_m = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 6; i++) shadow_m[c][i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (done_cnt !== d0) $display("FAIL reset_mid_done: got %0d expected %0d", done_cnt, d0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    load_ch0();
    for (int i = 0; i < 6; i++) write_cfg(1, i, $urandom_range(32'h7FFFFFFF, 0) << 1 | 32'h5);
    run_seq(0, 1'b0);
    test_bad_start();
    run_seq(0, 1'b1);
    ld = 2'b10;
    repeat (4) @(negedge clk);
    run_seq(1, 1'b0);
    ld = 2'b00;
    repeat (4) @(negedge clk);
    test_reset_mid();
    run_seq(1, 1'b0);
    load_ch0();
    run_seq(0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
